// File: rtl/memshare_sched_ctrl.sv
// Round-robin/aging scheduler sharing SHARE_NUM memory ports among REQ_NUM requesters per pipeline cycle.
// Optional statistics counters are enabled by defining MEMSHARE_SCHED_STATS_EN.
//   state | meaning
//   IDLE  | scheduler off, grants and flags cleared
//   ARB   | first clock of a pipeline cycle, arbitrate and register grants
//   HOLD  | remaining PIPE_CYCLE_LEN-1 clocks, grants held
`timescale 1ns/1ps
module memshare_sched_ctrl #(
    parameter int REQ_NUM        = 4,
    parameter int SHARE_NUM      = 2,
    parameter int PIPE_CYCLE_LEN = 4,
    parameter int AGE_MAX        = 3,
    localparam int PORT_W        = (SHARE_NUM > 1) ? $clog2(SHARE_NUM) : 1
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      sched_en,
    input  logic [REQ_NUM-1:0]        rqst_vec,
    output logic [REQ_NUM-1:0]        grant_vec,
    output logic [REQ_NUM*PORT_W-1:0] grant_port,
    output logic                      pipeCycle_begin_o,
    output logic                      rule1_hit,
    output logic                      rule2_hit,
    output logic                      rule3_hit,
`ifdef MEMSHARE_SCHED_STATS_EN
    output logic [15:0]               stat_pcycle_cnt,
    output logic [15:0]               stat_rule1_cnt,
    output logic [15:0]               stat_starve_cnt,
`endif
    output logic                      busy
);

    localparam int IDX_W = $clog2(REQ_NUM);
    localparam int CNT_W = $clog2(SHARE_NUM + 1);
    localparam int AGE_W = (AGE_MAX > 1) ? $clog2(AGE_MAX + 1) : 1;
    localparam int PH_W  = $clog2(PIPE_CYCLE_LEN);
    localparam int POP_W = $clog2(REQ_NUM + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_HOLD} state_t;

    state_t                         state_q, state_d;
    logic [PH_W-1:0]                phase_q, phase_d;
    logic [IDX_W-1:0]               rr_q, rr_d;
    logic [REQ_NUM-1:0][AGE_W-1:0]  age_q, age_d;
    logic [REQ_NUM-1:0]             grant_q, grant_d;
    logic [REQ_NUM-1:0][PORT_W-1:0] port_q, port_d;
    logic                           r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;

    logic [REQ_NUM-1:0]             urgent;
    logic [REQ_NUM-1:0]             arb_grant;
    logic [REQ_NUM-1:0][PORT_W-1:0] arb_port;
    logic [CNT_W-1:0]               arb_cnt;
    logic [IDX_W-1:0]               arb_last;
    logic [IDX_W-1:0]               rr_next;
    logic [POP_W-1:0]               req_pop;
    logic [IDX_W:0]                 scan_sum;
    logic [IDX_W-1:0]               scan_idx;
    logic                           arb_r1, arb_r2, arb_r3;

    // Two scans from rr_q: urgent requesters first, then the rest, until SHARE_NUM slots are used
    always_comb begin
        urgent    = '0;
        arb_grant = '0;
        arb_port  = '0;
        arb_cnt   = '0;
        arb_last  = rr_q;
        req_pop   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            urgent[i] = rqst_vec[i] && (age_q[i] == AGE_W'(AGE_MAX));
            req_pop   = req_pop + POP_W'(rqst_vec[i]);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < REQ_NUM; k++) begin
                scan_sum = {1'b0, rr_q} + (IDX_W+1)'(k);
                if (scan_sum >= (IDX_W+1)'(REQ_NUM)) begin
                    scan_sum = scan_sum - (IDX_W+1)'(REQ_NUM);
                end
                scan_idx = scan_sum[IDX_W-1:0];
                if (rqst_vec[scan_idx] && (urgent[scan_idx] == (pass == 0)) &&
                    (arb_cnt < CNT_W'(SHARE_NUM))) begin
                    arb_grant[scan_idx] = 1'b1;
                    arb_port[scan_idx]  = PORT_W'(arb_cnt);
                    arb_cnt             = arb_cnt + CNT_W'(1);
                    arb_last            = scan_idx;
                end
            end
        end
        rr_next = (arb_last == IDX_W'(REQ_NUM - 1)) ? '0 : arb_last + IDX_W'(1);
        arb_r1  = req_pop > POP_W'(SHARE_NUM);
        arb_r2  = |urgent;
        arb_r3  = (rqst_vec == '0);
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rr_d    = rr_q;
        age_d   = age_q;
        grant_d = grant_q;
        port_d  = port_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        case (state_q)
            ST_IDLE: begin
                if (sched_en) state_d = ST_ARB;
            end
            ST_ARB: begin
                state_d = ST_HOLD;
                phase_d = PH_W'(1);
                grant_d = arb_grant;
                port_d  = arb_port;
                r1_d    = arb_r1;
                r2_d    = arb_r2;
                r3_d    = arb_r3;
                if (arb_cnt != '0) rr_d = rr_next;
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (arb_grant[i] || !rqst_vec[i]) begin
                        age_d[i] = '0;
                    end else if (age_q[i] != AGE_W'(AGE_MAX)) begin
                        age_d[i] = age_q[i] + AGE_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (phase_q == PH_W'(PIPE_CYCLE_LEN - 1)) begin
                    phase_d = '0;
                    if (sched_en) begin
                        state_d = ST_ARB;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        port_d  = '0;
                        r1_d    = 1'b0;
                        r2_d    = 1'b0;
                        r3_d    = 1'b0;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rr_q    <= '0;
            age_q   <= '0;
            grant_q <= '0;
            port_q  <= '0;
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
            r3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rr_q    <= rr_d;
            age_q   <= age_d;
            grant_q <= grant_d;
            port_q  <= port_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
        end
    end

    assign grant_vec         = grant_q;
    assign grant_port        = port_q;
    assign rule1_hit         = r1_q;
    assign rule2_hit         = r2_q;
    assign rule3_hit         = r3_q;
    assign pipeCycle_begin_o = (state_q == ST_ARB);
    assign busy              = (state_q != ST_IDLE);

`ifdef MEMSHARE_SCHED_STATS_EN
    logic [15:0] pcyc_q, rule1_q, starve_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pcyc_q   <= '0;
            rule1_q  <= '0;
            starve_q <= '0;
        end else if (state_q == ST_ARB) begin
            if (pcyc_q != 16'hFFFF)               pcyc_q   <= pcyc_q + 16'd1;
            if (arb_r1 && rule1_q != 16'hFFFF)    rule1_q  <= rule1_q + 16'd1;
            if (arb_r2 && starve_q != 16'hFFFF)   starve_q <= starve_q + 16'd1;
        end
    end

    assign stat_pcycle_cnt = pcyc_q;
    assign stat_rule1_cnt  = rule1_q;
    assign stat_starve_cnt = starve_q;
`endif

endmodule
